// File: rtl/pe_loop_sequencer_if.sv
// Stream and control bundle of the nested-loop address sequencer.
// The controller drives config, control and ack; the sequencer drives the address stream.
interface pe_loop_sequencer_if #(
  parameter int NDEPTH = 4,
  parameter int IDW    = 6,
  parameter int AW     = 12
);
  logic                   i_start;
  logic                   i_stall;
  logic                   i_abort;
  logic [AW-1:0]          i_base;
  logic [NDEPTH*IDW-1:0]  i_bound;
  logic [NDEPTH*AW-1:0]   i_stride;
  logic                   o_rdy;
  logic                   i_ack;
  logic [AW-1:0]          o_addr;
  logic [NDEPTH*IDW-1:0]  o_idx;
  logic [NDEPTH-1:0]      o_end;
  logic                   o_busy;
  logic                   o_done;

  modport master (
    output i_start, i_stall, i_abort, i_base, i_bound, i_stride, i_ack,
    input  o_rdy, o_addr, o_idx, o_end, o_busy, o_done
  );

  modport slave (
    input  i_start, i_stall, i_abort, i_base, i_bound, i_stride, i_ack,
    output o_rdy, o_addr, o_idx, o_end, o_busy, o_done
  );
endinterface

// File: rtl/pe_loop_sequencer.sv
// N-deep nested-loop sequencer: walks programmable per-level bounds and emits
// one base+sum(offsets) address per iteration on a rdy/ack stream.
module pe_loop_sequencer #(
  parameter int NDEPTH = 4,
  parameter int IDW    = 6,
  parameter int AW     = 12
) (
  input logic                  i_clk,
  input logic                  i_rst,
  pe_loop_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_WORK, S_STALL} state_t;

  state_t                      state_q, state_d;
  logic [AW-1:0]               base_q;
  logic [NDEPTH-1:0][IDW-1:0]  bound_q;
  logic [NDEPTH-1:0][AW-1:0]   stride_q;
  logic [NDEPTH-1:0][IDW-1:0]  idx_q;
  logic [NDEPTH-1:0][AW-1:0]   off_q;
  logic                        done_q;

  logic [NDEPTH-1:0][IDW-1:0]  last_idx;
  logic [NDEPTH-1:0]           end_flag;
  logic [NDEPTH-1:0]           adv_lvl;
  logic                        last;
  logic                        xfer;
  logic                        do_latch, do_clear, do_adv, done_d;
  logic [AW-1:0]               addr_sum;

  // A zero bound behaves as a single-iteration level.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    last_idx = '0;
    end_flag = '0;
    adv_lvl  = '0;
    for (int k = 0; k < NDEPTH; k++) begin
      last_idx[k] = (bound_q[k] == '0) ? '0 : bound_q[k] - IDW'(1);
      end_flag[k] = (idx_q[k] == last_idx[k]);
    end
    // Level k steps only when every inner level is wrapping on this transfer.
    adv_lvl[0] = 1'b1;
    for (int k = 1; k < NDEPTH; k++) begin
      adv_lvl[k] = adv_lvl[k-1] & end_flag[k-1];
    end
  end

  assign last = &end_flag;
  assign xfer = (state_q == S_WORK) && bus.i_ack;

  always_comb begin
    addr_sum = base_q;
    for (int k = 0; k < NDEPTH; k++) begin
      addr_sum = addr_sum + off_q[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Abort wins everywhere outside IDLE and discards any same-cycle transfer.
  always_comb begin
    state_d  = state_q;
    do_latch = 1'b0;
    do_clear = 1'b0;
    do_adv   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start && !bus.i_abort) state_d = S_INIT;
      end
      S_INIT: begin
        do_clear = 1'b1;
        if (bus.i_abort) begin
          state_d = S_IDLE;
        end else begin
          do_latch = 1'b1;
          state_d  = S_WORK;
        end
      end
      S_WORK: begin
        if (bus.i_abort) begin
          state_d  = S_IDLE;
          do_clear = 1'b1;
        end else if (xfer) begin
          if (last) begin
            state_d  = S_IDLE;
            do_clear = 1'b1;
            done_d   = 1'b1;
          end else begin
            do_adv = 1'b1;
            if (bus.i_stall) state_d = S_STALL;
          end
        end
      end
      S_STALL: begin
        if (bus.i_abort) begin
          state_d  = S_IDLE;
          do_clear = 1'b1;
        end else if (!bus.i_stall) begin
          state_d = S_WORK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      // NOTE: the small per-level register arrays are reset explicitly; o_end's reset value depends on it.
      base_q   <= '0;
      bound_q  <= '0;
      stride_q <= '0;
      idx_q    <= '0;
      off_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_d;
      if (do_latch) begin
        base_q   <= bus.i_base;
        bound_q  <= bus.i_bound;
        stride_q <= bus.i_stride;
      end
      if (do_clear) begin
        idx_q <= '0;
        off_q <= '0;
      end else if (do_adv) begin
        for (int k = 0; k < NDEPTH; k++) begin
          if (adv_lvl[k]) begin
            if (end_flag[k]) begin
              idx_q[k] <= '0;
              off_q[k] <= '0;
            end else begin
              idx_q[k] <= idx_q[k] + IDW'(1);
              off_q[k] <= off_q[k] + stride_q[k];
            end
          end
        end
      end
    end
  end

  assign bus.o_rdy  = (state_q == S_WORK);
  assign bus.o_addr = addr_sum;
  assign bus.o_idx  = idx_q;
  assign bus.o_end  = end_flag;
  assign bus.o_busy = (state_q != S_IDLE);
  assign bus.o_done = done_q;

endmodule

// File: doc/pe_loop_sequencer.md
Name: pe_loop_sequencer

Overview:
- Parametrised N-deep nested-loop sequencer and address generator for the PE datapath controller.
- Replaces fixed-depth loop counting with programmable per-level bounds and strides.
- Emits one linear pad address per loop iteration on a rdy/ack stream, together with the loop indices and per-level loop-end flags.
- Supports start/stall/abort control and signals completion with a one-cycle done pulse.

Parameters:
NDEPTH, 4, number of nested loop levels; level 0 is innermost.
IDW, 6, index/bound width per level.
AW, 12, address width; all address arithmetic is modulo 2^AW.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-low reset
i_start  in  1  start pulse; honoured only in IDLE
i_stall  in  1  stall request
i_abort  in  1  abort; overrides all other inputs
i_base  in  AW  base address
i_bound  in  NDEPTH*IDW  loop size per level, level k at bits [k*IDW +: IDW]
i_stride  in  NDEPTH*AW  address stride per level, packed the same way
o_rdy  out  1  address valid (rdy of rdy/ack pair)
i_ack  in  1  consumer accept
o_addr  out  AW  current address
o_idx  out  NDEPTH*IDW  current loop indices
o_end  out  NDEPTH  o_end[k] = level k at its last index
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (i_rst low, async): state IDLE; indices, offsets and latched config all 0. Outputs: o_rdy=0, o_addr=0, o_idx=0, o_end=all 1s (bound 0 is treated as 1), o_busy=0, o_done=0.
- States: IDLE, INIT, WORK, STALL.
- IDLE→INIT: i_start=1 and i_abort=0.
- INIT (one cycle):
  - latch i_base, i_bound, i_stride;
  - clear indices and per-level offsets;
  - next state WORK.
  - Config changes after INIT have no effect until the next run.
- Latency: start sampled at cycle t gives o_rdy=1 at cycle t+2 with o_addr=base.
- Transfer: o_rdy && i_ack in the same cycle.
- Effective bound: eb[k] = (bound[k]==0) ? 1 : bound[k].
- Loop-end flags: o_end[k] = (idx[k] == eb[k]-1). Define last = &o_end.
- On each transfer:
  - level k advances iff o_end[j] holds for all j<k; level 0 always advances;
  - an advancing level that is at its end wraps idx to 0 and offset to 0;
  - otherwise it does idx+=1 and offset+=stride (mod 2^AW).
- Address: o_addr = base + sum of offset[k], mod 2^AW. It is combinational from registers; no multipliers.
- Final transfer (transfer while last=1):
  - next state IDLE;
  - o_done=1 for exactly the following cycle;
  - indices cleared.
- In WORK, o_rdy=1. o_rdy never drops without an ack.
- WORK→STALL: i_stall=1 in a transfer cycle that is not the final one. The transfer completes; counters advance. While i_stall=1 and no ack, the state stays WORK.
- STALL:
  - o_rdy=0; counters hold;
  - STALL→WORK when i_stall=0; o_rdy returns the next cycle with the held address.
- i_abort=1 in any non-IDLE state:
  - next state IDLE; o_rdy=0 next cycle;
  - indices and offsets cleared; no o_done.
  - Any transfer in the abort cycle is discarded; counters do not advance.
- i_start while busy: ignored.
- i_abort and i_start together in IDLE: stays IDLE.
- Total transfers per run = product of eb[k].
- o_busy is high in INIT, WORK and STALL.

Test Plan:
1. Basic nest, ack held high: NDEPTH=2 levels used (higher bounds 1), bound={3,2}, stride={1,8}, base=100. Required: o_addr = 100,101,102,108,109,110 on consecutive cycles; o_end[0] high on 102 and 110; o_done pulses one cycle after 110; o_busy falls with it.
2. Backpressure: same config, i_ack alternating 0/1. Required: each address is held stable until acked; sequence identical to scenario 1; o_rdy never drops mid-run.
3. Stall: i_stall asserted during the ack of address 101 and held 3 cycles. Required: o_rdy=0 for 3 cycles; resumes with 102; no address lost or duplicated.
4. Abort: i_abort during WORK at address 108. Required: o_rdy=0 and o_busy=0 next cycle; no o_done; a new i_start restarts from base 100.
5. Edge bounds: all bounds 0. Required: a single transfer with o_addr=base and o_end=all 1s, then o_done. Also base=4090, bound0=4, stride0=5, AW=12. Required: 4090, 4095, 4, 9.
6. Full depth: NDEPTH=4, bounds {2,2,2,2}, strides {1,2,4,8}, base 0. Required: addresses 0..15 in order, 16 transfers; i_start pulsed mid-run is ignored; async reset mid-run returns all outputs to reset values immediately.
